// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller slice.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2,
    ERR  = 2'd3
  } fetch_state_t;

  localparam logic [1:0]  ERR_NONE     = 2'b00;
  localparam logic [1:0]  ERR_MISALIGN = 2'b01;
  localparam logic [1:0]  ERR_TIMEOUT  = 2'b10;
  localparam logic [31:0] NOP_INSTR    = 32'h0;

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory read port between the fetch controller (master) and imem (slave).
interface ifetch_if #(
  parameter int ADDR_W = 16
);
  // imem_req/imem_addr stay asserted and stable until the cycle imem_ack is
  // seen high; that cycle completes the read with imem_rdata. An ack in any
  // other cycle carries no transfer and is dropped by the master.
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/ifetch_watchdog.sv
// Loadable/clearable cycle counter; hit flags the increment that reaches TIMEOUT.
module ifetch_watchdog #(
  parameter int TIMEOUT = 15,
  parameter int W       = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         hit
);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (load) cnt_d = load_val;
    else if (en)   cnt_d = cnt_q + 1'b1;
  end

  assign hit = en && !clr && !load && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch controller: one imem read per retired instruction, holds the word for
// decode/execute, and traps misaligned or timed-out fetches until reset.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      im_address,
  input  logic             exec_done,
  ifetch_if.master         imem,
  output logic [31:0]      instruction,
  output logic             inst_valid,
  output logic             pc_enable,
  output logic             fetch_err,
  output logic [1:0]       err_cause,
  output logic [CNT_W-1:0] stall_cnt,
  output fetch_state_t     state_dbg
);
  fetch_state_t     state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             wd_en, wd_clr, wd_hit;
  logic             misaligned;

  assign misaligned = (im_address[1:0] != 2'b00);

  ifetch_watchdog #(.TIMEOUT(TIMEOUT), .W(8)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst),
    .clr      (wd_clr),
    .load     (1'b0),
    .load_val (8'h00),
    .en       (wd_en),
    .hit      (wd_hit)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    cause_d = cause_q;
    stall_d = stall_q;
    wd_en   = 1'b0;
    wd_clr  = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (misaligned) begin
          state_d = ERR;
          err_d   = 1'b1;
          cause_d = ERR_MISALIGN;
        end else if (imem.imem_ack) begin
          // Ack beats a coincident timeout.
          instr_d = imem.imem_rdata;
          valid_d = 1'b1;
          wd_clr  = 1'b1;
          state_d = EXEC;
        end else begin
          wd_en = 1'b1;
          if (stall_q != {CNT_W{1'b1}}) stall_d = stall_q + 1'b1;
          if (wd_hit) begin
            state_d = ERR;
            err_d   = 1'b1;
            cause_d = ERR_TIMEOUT;
          end
        end
      end
      EXEC: begin
        if (exec_done) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cause_q <= ERR_NONE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cause_q <= cause_d;
      stall_q <= stall_d;
    end
  end

  // Request is decoded from the live address so a PC update at the EXEC->REQ
  // edge is fetched in the very next cycle.
  assign imem.imem_req  = (state_q == REQ) && !misaligned;
  assign imem.imem_addr = im_address[ADDR_W-1:0];
  assign pc_enable      = (state_q == EXEC) && exec_done;
  assign instruction    = instr_q;
  assign inst_valid     = valid_q;
  assign fetch_err      = err_q;
  assign err_cause      = cause_q;
  assign stall_cnt      = stall_q;
  assign state_dbg      = state_q;

  generate
    if (ADDR_W < 32) begin : g_unused_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^im_address[31:ADDR_W];
    end
  endgenerate
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a transaction-level fetch model.
module tb_ifetch_ctrl;
  import ifetch_pkg::*;

  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 16;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       im_address;
  logic              exec_done;
  logic [31:0]       instruction;
  logic              inst_valid, pc_enable, fetch_err;
  logic [1:0]        err_cause;
  logic [CNT_W-1:0]  stall_cnt;
  fetch_state_t      state_dbg;

  always #5 clk = ~clk;

  ifetch_if #(.ADDR_W(ADDR_W)) imem_bus ();

  ifetch_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .im_address  (im_address),
    .exec_done   (exec_done),
    .imem        (imem_bus),
    .instruction (instruction),
    .inst_valid  (inst_valid),
    .pc_enable   (pc_enable),
    .fetch_err   (fetch_err),
    .err_cause   (err_cause),
    .stall_cnt   (stall_cnt),
    .state_dbg   (state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic        m_boot, m_hold, m_dead;
  logic [1:0]  m_cause;
  logic [15:0] m_stall;
  int          m_wait;
  logic [31:0] m_instr;

  task automatic model_reset();
    m_boot = 1'b1; m_hold = 1'b0; m_dead = 1'b0;
    m_cause = 2'b00; m_stall = 16'h0; m_wait = 0; m_instr = 32'h0;
  endtask

  function automatic logic model_fetching();
    return !m_boot && !m_hold && !m_dead;
  endfunction

  task automatic check_model();
    logic exp_req;
    exp_req = model_fetching() && (im_address[1:0] == 2'b00);
    chk("rnd_req", imem_bus.imem_req, exp_req);
    if (exp_req) chk("rnd_addr", imem_bus.imem_addr, im_address[15:0]);
    chk("rnd_valid", inst_valid, m_hold);
    chk("rnd_instr", instruction, m_instr);
    chk("rnd_pc_en", pc_enable, m_hold && exec_done);
    chk("rnd_err", fetch_err, m_dead);
    chk("rnd_cause", err_cause, m_cause);
    chk("rnd_stall", stall_cnt, m_stall);
  endtask

  task automatic model_step();
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_hold) begin
      if (exec_done) m_hold = 1'b0;
    end else if (!m_dead) begin
      if (im_address[1:0] != 2'b00) begin
        m_dead = 1'b1; m_cause = 2'b01;
      end else if (imem_bus.imem_ack) begin
        m_instr = imem_bus.imem_rdata; m_hold = 1'b1; m_wait = 0;
      end else begin
        m_wait++;
        if (m_stall != 16'hFFFF) m_stall = m_stall + 16'h1;
        if (m_wait == TIMEOUT) begin
          m_dead = 1'b1; m_cause = 2'b10;
        end
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    exec_done = 1'b0;
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    repeat (2) step();
    rst = 1'b1;
    model_reset();
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 15) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic        done;
    logic        exp_req;
    logic        exp_valid;
    logic        exp_pc;
    logic [31:0] exp_instr;
    logic [15:0] exp_stall;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic [31:0] addr, logic ack, logic [31:0] rdata, logic done,
                              logic req, logic valid, logic pc, logic [31:0] instr, logic [15:0] st);
    vec_t v;
    v.addr = addr; v.ack = ack; v.rdata = rdata; v.done = done;
    v.exp_req = req; v.exp_valid = valid; v.exp_pc = pc; v.exp_instr = instr; v.exp_stall = st;
    return v;
  endfunction

  initial begin
    //             addr  ack rdata          done  req val pc instr          stall
    vecs[0]  = mk(32'h0, 0, 32'h0,          0,    0,  0,  0, 32'h0,          0); // IDLE
    vecs[1]  = mk(32'h0, 1, 32'h4C00_0001,  0,    1,  0,  0, 32'h0,          0); // ack in 1st REQ
    vecs[2]  = mk(32'h0, 0, 32'h0,          0,    0,  1,  0, 32'h4C00_0001,  0);
    vecs[3]  = mk(32'h0, 0, 32'h0,          1,    0,  1,  1, 32'h4C00_0001,  0); // retire
    vecs[4]  = mk(32'h4, 0, 32'h0,          0,    1,  0,  0, 32'h4C00_0001,  0);
    vecs[5]  = mk(32'h4, 0, 32'h0,          0,    1,  0,  0, 32'h4C00_0001,  1);
    vecs[6]  = mk(32'h4, 0, 32'h0,          0,    1,  0,  0, 32'h4C00_0001,  2);
    vecs[7]  = mk(32'h4, 1, 32'h0000_1111,  0,    1,  0,  0, 32'h4C00_0001,  3); // ack after 3
    vecs[8]  = mk(32'h4, 1, 32'hDEAD_BEEF,  0,    0,  1,  0, 32'h0000_1111,  3); // spurious ack
    vecs[9]  = mk(32'h4, 0, 32'h0,          1,    0,  1,  1, 32'h0000_1111,  3);
    vecs[10] = mk(32'h8, 0, 32'h0,          1,    1,  0,  0, 32'h0000_1111,  3); // done held in REQ
    vecs[11] = mk(32'h8, 1, 32'hABCD_0123,  1,    1,  0,  0, 32'h0000_1111,  4);
    vecs[12] = mk(32'h8, 0, 32'h0,          0,    0,  1,  0, 32'hABCD_0123,  4);
  end

  // ---------------- main test ----------------
  initial begin
    int ack_bias;
    logic fire;
    rst = 1'b0;
    im_address = 32'h0;
    exec_done = 1'b0;
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    repeat (2) step();

    // reset values
    chk("rst_state", state_dbg, IDLE);
    chk("rst_req", imem_bus.imem_req, 1'b0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_pc_en", pc_enable, 1'b0);
    chk("rst_err", fetch_err, 1'b0);
    chk("rst_cause", err_cause, 2'b00);
    chk("rst_stall", stall_cnt, 16'h0);

    // table: basic fetch, delayed ack, retire, exec_done in REQ, spurious ack
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      im_address = vecs[i].addr;
      imem_bus.imem_ack = vecs[i].ack;
      imem_bus.imem_rdata = vecs[i].rdata;
      exec_done = vecs[i].done;
      #1;
      chk($sformatf("vec%0d_req", i), imem_bus.imem_req, vecs[i].exp_req);
      if (vecs[i].exp_req) chk($sformatf("vec%0d_addr", i), imem_bus.imem_addr, vecs[i].addr[15:0]);
      chk($sformatf("vec%0d_valid", i), inst_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_pc_en", i), pc_enable, vecs[i].exp_pc);
      chk($sformatf("vec%0d_instr", i), instruction, vecs[i].exp_instr);
      chk($sformatf("vec%0d_stall", i), stall_cnt, vecs[i].exp_stall);
      chk($sformatf("vec%0d_err", i), fetch_err, 1'b0);
      step();
    end

    // misaligned fetch
    apply_reset();
    im_address = 32'h0000_0006;
    step();
    #1;
    chk("mis_req", imem_bus.imem_req, 1'b0);
    step();
    chk("mis_err", fetch_err, 1'b1);
    chk("mis_cause", err_cause, 2'b01);
    for (int k = 0; k < 3; k++) begin
      exec_done = 1'b1;
      #1;
      chk("mis_pc_en", pc_enable, 1'b0);
      step();
      exec_done = 1'b0;
      step();
    end
    chk("mis_sticky", fetch_err, 1'b1);

    // timeout after TIMEOUT ack-less REQ cycles
    apply_reset();
    im_address = 32'h0000_0100;
    step();
    for (int k = 0; k < TIMEOUT; k++) begin
      #1;
      chk("to_req", imem_bus.imem_req, 1'b1);
      chk("to_no_err", fetch_err, 1'b0);
      step();
    end
    chk("to_err", fetch_err, 1'b1);
    chk("to_cause", err_cause, 2'b10);
    chk("to_stall", stall_cnt, 16'(TIMEOUT));
    chk("to_req_off", imem_bus.imem_req, 1'b0);
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h1234_5678;
    step();
    imem_bus.imem_ack = 1'b0;
    chk("to_late_instr", instruction, 32'h0);
    chk("to_late_valid", inst_valid, 1'b0);

    // asynchronous reset in the middle of a request
    apply_reset();
    im_address = 32'h0000_0040;
    step();
    step();
    step();
    chk("ar_pre_stall", stall_cnt, 16'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_state", state_dbg, IDLE);
    chk("ar_req", imem_bus.imem_req, 1'b0);
    chk("ar_stall", stall_cnt, 16'd0);
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h5555_AAAA;
    #1;
    rst = 1'b1;
    #1;
    chk("ar_idle_req", imem_bus.imem_req, 1'b0);
    step();
    imem_bus.imem_ack = 1'b0;
    chk("ar_idle_valid", inst_valid, 1'b0);
    chk("ar_idle_instr", instruction, 32'h0);
    #1;
    chk("ar_fresh_req", imem_bus.imem_req, 1'b1);
    step();
    chk("ar_fresh_stall", stall_cnt, 16'd1);

    // randomized traffic against the model
    apply_reset();
    im_address = rnd_addr();
    ack_bias = 3;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) ack_bias = $urandom_range(0, 6);
      if ((m_dead && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        im_address = rnd_addr();
        #1;
        model_reset();
        check_model();
        step();
        rst = 1'b1;
        continue;
      end
      imem_bus.imem_ack = ($urandom_range(0, 9) < ack_bias);
      imem_bus.imem_rdata = $urandom;
      exec_done = 1'($urandom_range(0, 1));
      #1;
      check_model();
      fire = m_hold && exec_done;
      model_step();
      step();
      if (fire) im_address = rnd_addr();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
